mc_control_rv32i: RTL and testbench

MC_CONTROL_RV32I -- requirements
Module: mc_control_rv32i

---
 rtl/mc_control_rv32i.sv | 215 +++++++++++++++++++++
 tb/tb_mc_control_rv32i.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_rv32i.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes the datapath strobes from the current state.
module mc_control_rv32i #(
  parameter int MEM_WAIT_EN     = 1,
  parameter int MEM_TIMEOUT     = 16,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [6:0] i_opcode,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic       o_i_or_d,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_reg_write,
  output logic [1:0] o_mem_to_reg,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_pc_src,
  output logic       o_trap,
  output logic [1:0] o_trap_cause,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_LOAD  = 4'd3,
    S_LOAD_WB   = 4'd4,
    S_MEM_STORE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JAL       = 4'd9,
    S_JALR      = 4'd10,
    S_EXEC_I    = 4'd11,
    S_LUI       = 4'd12,
    S_AUIPC     = 4'd13,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] STALL_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] STALL_MAX  = '1;

  state_t           r_state;
  logic [6:0]       r_opcode;
  logic [CNT_W-1:0] r_stall;
  logic [1:0]       r_cause;

  logic   w_mem_done;
  logic   w_timeout;
  state_t w_mem_next;

  assign w_mem_done = (MEM_WAIT_EN == 0) || i_mem_ready;
  // The stall that would make the count reach MEM_TIMEOUT traps on this edge.
  assign w_timeout  = (MEM_WAIT_EN != 0) && (MEM_TIMEOUT > 0) && !i_mem_ready &&
                      (r_stall == STALL_LAST);

  always_comb begin
    w_mem_next = S_FETCH;
    if (r_state == S_FETCH)         w_mem_next = S_DECODE;
    else if (r_state == S_MEM_LOAD) w_mem_next = S_LOAD_WB;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_FETCH;
      r_opcode <= '0;
      r_stall  <= '0;
      r_cause  <= 2'd0;
    end else begin
      case (r_state)
        S_FETCH, S_MEM_LOAD, S_MEM_STORE: begin
          if (w_mem_done) begin
            r_state <= w_mem_next;
            r_stall <= '0;
          end else if (w_timeout) begin
            r_state <= S_TRAP;
            r_cause <= 2'd2;
            r_stall <= '0;
          end else if (r_stall != STALL_MAX) begin
            r_stall <= r_stall + 1'b1;
          end
        end
        S_DECODE: begin
          r_opcode <= i_opcode;
          case (i_opcode)
            OPC_LOAD, OPC_STORE: r_state <= S_MEM_ADDR;
            OPC_OP:              r_state <= S_EXEC_R;
            OPC_OPIMM:           r_state <= S_EXEC_I;
            OPC_BRANCH:          r_state <= S_BRANCH;
            OPC_JAL:             r_state <= S_JAL;
            OPC_JALR:            r_state <= S_JALR;
            OPC_LUI:             r_state <= S_LUI;
            OPC_AUIPC:           r_state <= S_AUIPC;
            default: begin
              if (TRAP_ON_ILLEGAL != 0) begin
                r_state <= S_TRAP;
                r_cause <= 2'd1;
              end else begin
                r_state <= S_FETCH;
              end
            end
          endcase
        end
        S_MEM_ADDR: r_state <= (r_opcode == OPC_STORE) ? S_MEM_STORE : S_MEM_LOAD;
        S_LOAD_WB, S_ALU_WB, S_BRANCH, S_JAL, S_JALR: r_state <= S_FETCH;
        S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: r_state <= S_ALU_WB;
        S_TRAP: r_state <= S_TRAP;
        default: begin
          r_state <= S_TRAP;
          r_cause <= 2'd1;
        end
      endcase
    end
  end

  assign o_state      = r_state;
  assign o_trap_cause = r_cause;

  always_comb begin
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_i_or_d        = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_ir_write      = 1'b0;
    o_reg_write     = 1'b0;
    o_mem_to_reg    = 2'd0;
    o_alu_src_a     = 2'd0;
    o_alu_src_b     = 2'd0;
    o_alu_op        = 2'd0;
    o_pc_src        = 2'd0;
    o_trap          = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = 2'd1;
        o_ir_write  = w_mem_done;
        o_pc_write  = w_mem_done;
      end
      S_DECODE:    o_alu_src_b = 2'd2;
      S_MEM_ADDR: begin
        o_alu_src_a = 2'd1;
        o_alu_src_b = 2'd2;
      end
      S_MEM_LOAD: begin
        o_mem_read = 1'b1;
        o_i_or_d   = 1'b1;
      end
      S_MEM_STORE: begin
        o_i_or_d    = 1'b1;
        o_mem_write = 1'b1;
      end
      S_LOAD_WB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 2'd1;
      end
      S_EXEC_R: begin
        o_alu_src_a = 2'd1;
        o_alu_op    = 2'd2;
      end
      S_EXEC_I: begin
        o_alu_src_a = 2'd1;
        o_alu_src_b = 2'd2;
        o_alu_op    = 2'd3;
      end
      S_LUI: begin
        o_alu_src_a = 2'd2;
        o_alu_src_b = 2'd2;
      end
      S_AUIPC:     o_alu_src_b = 2'd2;
      S_ALU_WB:    o_reg_write = 1'b1;
      S_BRANCH: begin
        o_alu_src_a     = 2'd1;
        o_alu_op        = 2'd1;
        o_pc_write_cond = 1'b1;
        o_pc_src        = 2'd1;
      end
      S_JAL: begin
        o_pc_write   = 1'b1;
        o_pc_src     = 2'd1;
        o_reg_write  = 1'b1;
        o_mem_to_reg = 2'd2;
      end
      S_JALR: begin
        o_alu_src_a  = 2'd1;
        o_alu_src_b  = 2'd2;
        o_pc_write   = 1'b1;
        o_pc_src     = 2'd2;
        o_reg_write  = 1'b1;
        o_mem_to_reg = 2'd2;
      end
      S_TRAP:  o_trap = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_rv32i.sv
// Bench for mc_control_rv32i: two configurations driven in parallel, checked every
// cycle against a table-driven model, plus directed sequences with literal expectations.
module tb_mc_control_rv32i;

  localparam int A_WAIT = 1, A_TMO = 4, A_TOI = 1;
  localparam int B_WAIT = 0, B_TMO = 0, B_TOI = 0;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OPR = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam logic [6:0] ILL = 7'b1111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [6:0] opc = 7'd0;
  logic       rdy = 1'b0;

  logic a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_irw, a_rw, a_trap;
  logic [1:0] a_m2r, a_sa, a_sb, a_aop, a_ps, a_cause;
  logic [3:0] a_state;
  logic b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_irw, b_rw, b_trap;
  logic [1:0] b_m2r, b_sa, b_sb, b_aop, b_ps, b_cause;
  logic [3:0] b_state;

  mc_control_rv32i #(.MEM_WAIT_EN(A_WAIT), .MEM_TIMEOUT(A_TMO), .TRAP_ON_ILLEGAL(A_TOI)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_opcode(opc), .i_mem_ready(rdy),
    .o_pc_write(a_pcw), .o_pc_write_cond(a_pcwc), .o_i_or_d(a_iord), .o_mem_read(a_mr),
    .o_mem_write(a_mw), .o_ir_write(a_irw), .o_reg_write(a_rw), .o_mem_to_reg(a_m2r),
    .o_alu_src_a(a_sa), .o_alu_src_b(a_sb), .o_alu_op(a_aop), .o_pc_src(a_ps),
    .o_trap(a_trap), .o_trap_cause(a_cause), .o_state(a_state));

  mc_control_rv32i #(.MEM_WAIT_EN(B_WAIT), .MEM_TIMEOUT(B_TMO), .TRAP_ON_ILLEGAL(B_TOI)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_opcode(opc), .i_mem_ready(rdy),
    .o_pc_write(b_pcw), .o_pc_write_cond(b_pcwc), .o_i_or_d(b_iord), .o_mem_read(b_mr),
    .o_mem_write(b_mw), .o_ir_write(b_irw), .o_reg_write(b_rw), .o_mem_to_reg(b_m2r),
    .o_alu_src_a(b_sa), .o_alu_src_b(b_sb), .o_alu_op(b_aop), .o_pc_src(b_ps),
    .o_trap(b_trap), .o_trap_cause(b_cause), .o_state(b_state));

  logic [23:0] out_a, out_b;
  assign out_a = {a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_irw, a_rw, a_m2r, a_sa, a_sb,
                  a_aop, a_ps, a_trap, a_cause, a_state};
  assign out_b = {b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_irw, b_rw, b_m2r, b_sa, b_sb,
                  b_aop, b_ps, b_trap, b_cause, b_state};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural step number, stall count, cause, latched opcode.
  typedef struct {
    int         st;
    int         stall;
    int         cause;
    logic [6:0] opc;
  } mst_t;

  mst_t m_a, m_b;
  logic mvalid = 1'b0;

  function automatic int dec_target(input logic [6:0] o);
    case (o)
      LOAD, STORE: return 2;
      OPR:         return 6;
      OPI:         return 11;
      BR:          return 8;
      JAL:         return 9;
      JALR:        return 10;
      LUI:         return 12;
      AUIPC:       return 13;
      default:     return -1;
    endcase
  endfunction

  function automatic mst_t next_m(input mst_t c, input int wait_en, input int tmo, input int toi);
    mst_t n = c;
    int   t;
    if (rst) begin
      n.st = 0; n.stall = 0; n.cause = 0; n.opc = 7'd0;
      return n;
    end
    case (c.st)
      0, 3, 5: begin
        if (wait_en == 0 || rdy) begin
          n.st    = (c.st == 0) ? 1 : (c.st == 3) ? 4 : 0;
          n.stall = 0;
        end else begin
          n.stall = c.stall + 1;
          if (tmo > 0 && n.stall >= tmo) begin
            n.st = 15; n.cause = 2; n.stall = 0;
          end
        end
      end
      1: begin
        n.opc = opc;
        t = dec_target(opc);
        if (t >= 0)        n.st = t;
        else if (toi != 0) begin n.st = 15; n.cause = 1; end
        else               n.st = 0;
      end
      2:                 n.st = (c.opc == STORE) ? 5 : 3;
      4, 7, 8, 9, 10:    n.st = 0;
      6, 11, 12, 13:     n.st = 7;
      default:           n.st = c.st;
    endcase
    return n;
  endfunction

  function automatic logic [23:0] exp_out(input mst_t c, input int wait_en);
    logic pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0, rw = 0, tr = 0;
    logic [1:0] m2r = 0, sa = 0, sb = 0, aop = 0, ps = 0;
    logic [31:0] cs = c.st;
    logic [31:0] cc = c.cause;
    case (c.st)
      0:  begin mr = 1; sb = 1; irw = (wait_en != 0) ? rdy : 1'b1; pcw = irw; end
      1:  sb = 2;
      2:  begin sa = 1; sb = 2; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin sa = 1; aop = 2; end
      7:  rw = 1;
      8:  begin sa = 1; aop = 1; pcwc = 1; ps = 1; end
      9:  begin pcw = 1; ps = 1; rw = 1; m2r = 2; end
      10: begin sa = 1; sb = 2; pcw = 1; ps = 2; rw = 1; m2r = 2; end
      11: begin sa = 1; sb = 2; aop = 3; end
      12: begin sa = 2; sb = 2; end
      13: sb = 2;
      15: tr = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, rw, m2r, sa, sb, aop, ps, tr, cc[1:0], cs[3:0]};
  endfunction

  always @(posedge clk) begin
    m_a <= next_m(m_a, A_WAIT, A_TMO, A_TOI);
    m_b <= next_m(m_b, B_WAIT, B_TMO, B_TOI);
    if (rst) mvalid <= 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("model_cmp_a", {8'd0, out_a}, {8'd0, exp_out(m_a, A_WAIT)});
      check("model_cmp_b", {8'd0, out_b}, {8'd0, exp_out(m_b, B_WAIT)});
    end
  end

  // Inputs change just after the rising edge; outputs are inspected at the falling edge.
  task automatic tick(input logic r, input logic [6:0] o, input logic d);
    @(posedge clk);
    #2;
    rst = r; opc = o; rdy = d;
    @(negedge clk);
  endtask

  logic [6:0] legal [9];
  int exp_seq [6];
  int bias;

  initial begin
    legal = '{LOAD, STORE, OPR, OPI, BR, JAL, JALR, LUI, AUIPC};

    // Load with ready high
    tick(1, LOAD, 1);
    exp_seq = '{0, 1, 2, 3, 4, 0};
    for (int i = 0; i < 6; i++) begin
      tick(0, LOAD, 1);
      check("load_state", {28'd0, a_state}, exp_seq[i]);
      check("load_regwr", {31'd0, a_rw}, (exp_seq[i] == 4) ? 1 : 0);
      if (i == 0) begin
        check("reset_trap", {31'd0, a_trap}, 0);
        check("reset_fetch_srcb", {30'd0, a_sb}, 1);
        check("model_pin_fetch", m_a.st, 0);
      end
      if (exp_seq[i] == 4) check("load_m2r", {30'd0, a_m2r}, 1);
    end

    // Fetch stall of 3 cycles, ready on the 4th (also the timeout boundary: ready wins)
    tick(1, OPR, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, OPR, (i == 3));
      check("fstall_state", {28'd0, a_state}, 0);
      check("fstall_irw", {31'd0, a_irw}, (i == 3) ? 1 : 0);
      check("fstall_pcw", {31'd0, a_pcw}, (i == 3) ? 1 : 0);
    end
    tick(0, OPR, 1);
    check("fstall_decode", {28'd0, a_state}, 1);
    check("model_pin_decode", m_a.st, 1);

    // Store timeout after 4 stalled cycles
    tick(1, STORE, 1);
    tick(0, STORE, 1);
    tick(0, STORE, 1);
    tick(0, STORE, 1);
    check("store_addr", {28'd0, a_state}, 2);
    for (int i = 0; i < 4; i++) begin
      tick(0, STORE, 0);
      check("store_hold", {28'd0, a_state}, 5);
      check("store_mw", {31'd0, a_mw}, 1);
    end
    tick(0, STORE, 0);
    check("tmo_state", {28'd0, a_state}, 15);
    check("tmo_trap", {31'd0, a_trap}, 1);
    check("tmo_cause", {30'd0, a_cause}, 2);
    check("tmo_mw", {31'd0, a_mw}, 0);

    // Illegal opcode: trap in A, NOP in B
    tick(1, ILL, 1);
    tick(0, ILL, 1);
    check("ill_b_fetch", {28'd0, b_state}, 0);
    tick(0, ILL, 1);
    check("ill_a_decode", {28'd0, a_state}, 1);
    check("ill_b_strobes", {28'd0, b_pcw, b_rw, b_mw, b_irw}, 0);
    tick(0, ILL, 1);
    check("ill_a_trap", {28'd0, a_state}, 15);
    check("ill_a_cause", {30'd0, a_cause}, 1);
    check("ill_b_back", {28'd0, b_state}, 0);
    tick(0, LOAD, 1);
    tick(0, LOAD, 1);
    check("ill_a_absorb", {28'd0, a_state}, 15);
    check("model_pin_trap", m_a.cause, 1);

    // Reset out of TRAP
    tick(1, LOAD, 1);
    tick(0, JALR, 1);
    check("trap_rst_state", {28'd0, a_state}, 0);
    check("trap_rst_cause", {30'd0, a_cause}, 0);
    check("trap_rst_trap", {31'd0, a_trap}, 0);

    // JALR: 0,1,10,0
    tick(0, JALR, 1);
    check("jalr_decode", {28'd0, a_state}, 1);
    tick(0, JALR, 1);
    check("jalr_state", {28'd0, a_state}, 10);
    check("jalr_fields", {24'd0, a_ps, a_m2r, a_pcw, a_rw, 2'b00}, {24'd0, 2'd2, 2'd2, 1'b1, 1'b1, 2'b00});
    tick(0, JALR, 1);
    check("jalr_back", {28'd0, a_state}, 0);

    // Reset mid-stall must clear the stall count
    tick(1, LOAD, 0);
    for (int i = 0; i < 3; i++) tick(0, LOAD, 0);
    tick(1, LOAD, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, LOAD, 0);
      check("rst_stall_hold", {28'd0, a_state}, 0);
    end
    tick(0, LOAD, 1);
    tick(0, LOAD, 1);
    check("rst_stall_decode", {28'd0, a_state}, 1);

    // Randomized traffic, checked by the model process
    bias = 1;
    for (int i = 0; i < 4000; i++) begin
      logic       r, d;
      logic [6:0] o;
      int         sel;
      if (i % 200 == 0) bias = $urandom_range(0, 3);
      r   = ($urandom_range(0, 39) == 0);
      sel = $urandom_range(0, 11);
      o   = (sel < 9) ? legal[sel] : 7'($urandom);
      d   = (bias == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
      tick(r, o, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
